sdcard_rx_data_fifo: RTL

- Receive-path buffer between the SD card data-line deserializer and the DMA controller.
- Packs incoming card bytes into little-endian 32-bit words and stores them in a synchronous FIFO.
- Presents the FIFO to the DMA controller as show-ahead (first-word-fall-through): fifo_data_out is valid in the same cycle fifo_read is asserted.
- Supplies backpressure to the data path, and sticky overflow/underflow flags to the error block.

---
 rtl/sdcard_rx_data_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sdcard_rx_data_fifo.sv
// SD card receive data buffer: packs card bytes into little-endian 32-bit words
// and queues them in a show-ahead FIFO for the DMA. Optional watermark IRQ: SDCARD_RXFIFO_WM_IRQ_EN.
module sdcard_rx_data_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = $clog2(DEPTH),
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic          PCLK_i,
  input  logic          PRESETn_i,
  input  logic [7:0]    rx_byte_i,
  input  logic          rx_byte_valid_i,
  input  logic          rx_block_end_i,
  output logic          rx_ready_o,
  input  logic          flush_i,
  output logic [31:0]   fifo_data_out,
  input  logic          fifo_read,
  output logic          fifo_empty,
  output logic          fifo_full_o,
  output logic [AW:0]   fifo_level_o,
  output logic          overflow_o,
  output logic          underflow_o,
`ifdef SDCARD_RXFIFO_WM_IRQ_EN
  input  logic [AW:0]   wm_thresh_i,
  output logic          wm_irq_o,
`endif
  input  logic          err_clear_i
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AFULL = (AW+1)'(AFULL_THRESH);

  logic [1:0]    r_k;
  logic [31:0]   r_shift;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic          r_udf;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_word;
  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic          w_empty;
  logic          w_full;
  logic [AW:0]   w_level_nxt;

  function automatic logic [31:0] insert_byte(input logic [31:0] word, input logic [7:0] b,
                                              input logic [1:0] k, input logic vld);
    logic [31:0] lane;
    lane = {24'h0, b} << {k, 3'b000};
    return vld ? (word | lane) : word;
  endfunction

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_DEPTH);

  // Upper bytes of r_shift stay zero because it is cleared on every push.
  assign w_word    = insert_byte(r_shift, rx_byte_i, r_k, rx_byte_valid_i);
  assign w_push    = (rx_byte_valid_i && (r_k == 2'd3)) ||
                     (rx_block_end_i && ((r_k != 2'd0) || rx_byte_valid_i));
  assign w_pop     = fifo_read && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = !flush_i && w_push && w_full && !w_pop;
  assign w_udf_set = !flush_i && fifo_read && w_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (flush_i) begin
      w_level_nxt = '0;
    end else begin
      case ({w_push_ok, w_pop})
        2'b10:   w_level_nxt = r_level + 1'b1;
        2'b01:   w_level_nxt = r_level - 1'b1;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      r_k      <= '0;
      r_shift  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_k      <= '0;
      r_shift  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_level <= w_level_nxt;
      if (w_push) begin
        r_k     <= '0;
        r_shift <= '0;
      end else if (rx_byte_valid_i) begin
        r_k     <= r_k + 2'd1;
        r_shift <= w_word;
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the output mux hides stale contents while empty.
  always_ff @(posedge PCLK_i) begin
    if (!flush_i && w_push_ok) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set || (r_ovf && !err_clear_i);
      r_udf <= w_udf_set || (r_udf && !err_clear_i);
    end
  end

`ifdef SDCARD_RXFIFO_WM_IRQ_EN
  logic r_wm_irq;

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      r_wm_irq <= 1'b0;
    end else begin
      r_wm_irq <= (wm_thresh_i != '0) && (r_level < wm_thresh_i) &&
                  (w_level_nxt >= wm_thresh_i);
    end
  end

  assign wm_irq_o = r_wm_irq;
`endif

  assign fifo_data_out = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign fifo_empty    = w_empty;
  assign fifo_full_o   = w_full;
  assign fifo_level_o  = r_level;
  assign rx_ready_o    = (r_level < C_AFULL);
  assign overflow_o    = r_ovf;
  assign underflow_o   = r_udf;

endmodule
